// File: rtl/status_frame_receiver.sv
// status_frame_receiver
//
// Receive-side frame engine for the motor-board UART bus. It hunts a 32-bit
// magic word in the byte stream from uart_rx and collects ID, payload and
// CRC16 (poly 0x8005, init 0xFFFF, MSB first). Good frames are handed to the
// register bank through a one-entry valid/ready buffer.
//
// Ports
//   clk, reset             : clock, asynchronous active-high reset
//   rx_data_ready, rx_data : byte strobe (rising edge counts) and byte
//   id_check_en, expected_id : optional ID filter
//   frame_valid/frame_ready : output buffer handshake
//   frame_id, frame_payload : buffered frame (payload byte 0 in [7:0])
//   crc_error, id_mismatch, timeout_error, overrun : one-cycle event pulses
//   good_count, bad_count  : saturating frame counters
//   busy                   : high while a frame is being received or checked
module status_frame_receiver #(
  parameter logic [31:0] MAGIC              = 32'h1CEB00DA,
  parameter int          PAYLOAD_BYTES      = 21,
  parameter int          CLK_FREQ_HZ        = 50_000_000,
  parameter int          BAUDRATE           = 2_000_000,
  parameter int          TIMEOUT_BYTE_TIMES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_data_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       id_check_en,
  input  logic [7:0]                 expected_id,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [7:0]                 frame_id,
  output logic [8*PAYLOAD_BYTES-1:0] frame_payload,
  output logic                       crc_error,
  output logic                       id_mismatch,
  output logic                       timeout_error,
  output logic                       overrun,
  output logic [15:0]                good_count,
  output logic [15:0]                bad_count,
  output logic                       busy
);

  localparam int TIMEOUT = CLK_FREQ_HZ / BAUDRATE * 10 * TIMEOUT_BYTE_TIMES;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam int IDX_W   = $clog2(PAYLOAD_BYTES + 3);
  localparam int PW      = 8 * PAYLOAD_BYTES;

  typedef enum logic [1:0] {HUNT, RECEIVE, CHECK} state_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int k = 7; k >= 0; k--) begin
      if (c[15] ^ b[k]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state_q, state_d;
  logic               rx_prev_q;
  logic [23:0]        magic_sr_q, magic_sr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               frame_valid_q, frame_valid_d;
  logic [7:0]         frame_id_q, frame_id_d;
  logic [PW-1:0]      frame_payload_q, frame_payload_d;
  logic               crc_error_q, crc_error_d;
  logic               id_mismatch_q, id_mismatch_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;
  logic [15:0]        good_q, good_d;
  logic [15:0]        bad_q, bad_d;
  // Frame assembly registers; contents only matter once the FSM reaches CHECK.
  logic [7:0]         id_buf_q, id_buf_d;
  logic [PW-1:0]      pay_buf_q, pay_buf_d;
  logic [PW+7:0]      pay_shift;
  logic [15:0]        crc_q, crc_d;
  logic [7:0]         crc_hi_q, crc_hi_d;
  logic [7:0]         crc_lo_q, crc_lo_d;
  logic               byte_evt;

  assign byte_evt  = rx_data_ready & ~rx_prev_q;
  // Payload arrives byte 0 first; shifting in from the top leaves byte 0 in [7:0].
  assign pay_shift = {rx_data, pay_buf_q};

  always_comb begin
    state_d         = state_q;
    magic_sr_d      = magic_sr_q;
    idx_d           = idx_q;
    timer_d         = timer_q;
    frame_valid_d   = frame_valid_q & ~frame_ready;
    frame_id_d      = frame_id_q;
    frame_payload_d = frame_payload_q;
    crc_error_d     = 1'b0;
    id_mismatch_d   = 1'b0;
    timeout_d       = 1'b0;
    overrun_d       = 1'b0;
    good_d          = good_q;
    bad_d           = bad_q;
    id_buf_d        = id_buf_q;
    pay_buf_d       = pay_buf_q;
    crc_d           = crc_q;
    crc_hi_d        = crc_hi_q;
    crc_lo_d        = crc_lo_q;

    case (state_q)
      HUNT: begin
        if (byte_evt) begin
          magic_sr_d = {magic_sr_q[15:0], rx_data};
          if ({magic_sr_q, rx_data} == MAGIC) begin
            state_d    = RECEIVE;
            idx_d      = '0;
            crc_d      = 16'hFFFF;
            timer_d    = '0;
            magic_sr_d = '0;
          end
        end
      end
      RECEIVE: begin
        if (byte_evt) begin
          timer_d = '0;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == '0) begin
            id_buf_d = rx_data;
            crc_d    = crc16_step(crc_q, rx_data);
          end else if (idx_q <= IDX_W'(PAYLOAD_BYTES)) begin
            pay_buf_d = pay_shift[PW+7:8];
            crc_d     = crc16_step(crc_q, rx_data);
          end else if (idx_q == IDX_W'(PAYLOAD_BYTES + 1)) begin
            crc_hi_d = rx_data;
          end else begin
            crc_lo_d = rx_data;
            state_d  = CHECK;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          bad_d     = sat_inc(bad_q);
          state_d   = HUNT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      CHECK: begin
        state_d = HUNT;
        if ({crc_hi_q, crc_lo_q} != crc_q) begin
          crc_error_d = 1'b1;
          bad_d       = sat_inc(bad_q);
        end else if (id_check_en && (id_buf_q != expected_id)) begin
          // Frame addressed to another motor: silently ignored by the counters.
          id_mismatch_d = 1'b1;
        end else if (frame_valid_q && !frame_ready) begin
          overrun_d = 1'b1;
          bad_d     = sat_inc(bad_q);
        end else begin
          frame_valid_d   = 1'b1;
          frame_id_d      = id_buf_q;
          frame_payload_d = pay_buf_q;
          good_d          = sat_inc(good_q);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= HUNT;
      rx_prev_q       <= 1'b0;
      magic_sr_q      <= '0;
      idx_q           <= '0;
      timer_q         <= '0;
      frame_valid_q   <= 1'b0;
      frame_id_q      <= '0;
      frame_payload_q <= '0;
      crc_error_q     <= 1'b0;
      id_mismatch_q   <= 1'b0;
      timeout_q       <= 1'b0;
      overrun_q       <= 1'b0;
      good_q          <= '0;
      bad_q           <= '0;
    end else begin
      state_q         <= state_d;
      rx_prev_q       <= rx_data_ready;
      magic_sr_q      <= magic_sr_d;
      idx_q           <= idx_d;
      timer_q         <= timer_d;
      frame_valid_q   <= frame_valid_d;
      frame_id_q      <= frame_id_d;
      frame_payload_q <= frame_payload_d;
      crc_error_q     <= crc_error_d;
      id_mismatch_q   <= id_mismatch_d;
      timeout_q       <= timeout_d;
      overrun_q       <= overrun_d;
      good_q          <= good_d;
      bad_q           <= bad_d;
    end
  end

  always_ff @(posedge clk) begin
    id_buf_q  <= id_buf_d;
    pay_buf_q <= pay_buf_d;
    crc_q     <= crc_d;
    crc_hi_q  <= crc_hi_d;
    crc_lo_q  <= crc_lo_d;
  end

  assign frame_valid   = frame_valid_q;
  assign frame_id      = frame_id_q;
  assign frame_payload = frame_payload_q;
  assign crc_error     = crc_error_q;
  assign id_mismatch   = id_mismatch_q;
  assign timeout_error = timeout_q;
  assign overrun       = overrun_q;
  assign good_count    = good_q;
  assign bad_count     = bad_q;
  assign busy          = (state_q != HUNT);

endmodule

// File: tb/tb_status_frame_receiver.sv
// Directed bench for status_frame_receiver: good frame, CRC error, ID filter,
// inter-byte timeout, overrun with and without same-cycle release, resync on
// an overlapping magic and asynchronous reset mid-frame.
module tb_status_frame_receiver;
  localparam int P  = 21;
  localparam int PW = 8 * P;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_data_ready;
  logic [7:0]    rx_data;
  logic          id_check_en;
  logic [7:0]    expected_id;
  logic          frame_valid;
  logic          frame_ready;
  logic [7:0]    frame_id;
  logic [PW-1:0] frame_payload;
  logic          crc_error, id_mismatch, timeout_error, overrun;
  logic [15:0]   good_count, bad_count;
  logic          busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_bad  = 16'd0;

  always #5 clk = ~clk;

  status_frame_receiver dut (
    .clk(clk), .reset(reset), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .id_check_en(id_check_en), .expected_id(expected_id),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_id(frame_id),
    .frame_payload(frame_payload), .crc_error(crc_error), .id_mismatch(id_mismatch),
    .timeout_error(timeout_error), .overrun(overrun), .good_count(good_count),
    .bad_count(bad_count), .busy(busy)
  );

  // CRC16 x^16+x^15+x^2+1, init FFFF, over ID and payload (payload byte k = base+k).
  function automatic logic [15:0] crc_model(input logic [7:0] id, input logic [7:0] base);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int n = 0; n <= P; n++) begin
      b = (n == 0) ? id : base + 8'(n - 1);
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  function automatic logic [PW-1:0] payload_of(input logic [7:0] base);
    logic [PW-1:0] p;
    for (int k = 0; k < P; k++) p[k*8 +: 8] = base + 8'(k);
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(posedge clk); #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic send_magic();
    send_byte(8'h1C); send_byte(8'hEB); send_byte(8'h00); send_byte(8'hDA);
  endtask

  // Returns during the CHECK cycle (one cycle after the last byte event).
  task automatic send_frame(input logic [7:0] id, input logic [7:0] base, input logic [15:0] flip);
    logic [15:0] c;
    c = crc_model(id, base) ^ flip;
    send_magic();
    send_byte(id);
    for (int k = 0; k < P; k++) send_byte(base + 8'(k));
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", frame_valid); else n_pass++;
    n_checks++; if (frame_id !== 8'h00) $display("FAIL rst_id: got %02h want 00", frame_id); else n_pass++;
    n_checks++; if (frame_payload !== '0) $display("FAIL rst_payload: got %h want 0", frame_payload); else n_pass++;
    n_checks++; if ({crc_error, id_mismatch, timeout_error, overrun} !== 4'b0000)
      $display("FAIL rst_pulses: got %b want 0000", {crc_error, id_mismatch, timeout_error, overrun}); else n_pass++;
    n_checks++; if (good_count !== 16'd0) $display("FAIL rst_good: got %0d want 0", good_count); else n_pass++;
    n_checks++; if (bad_count !== 16'd0) $display("FAIL rst_bad: got %0d want 0", bad_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_good_frame();
    send_magic();
    n_checks++; if (busy !== 1'b1) $display("FAIL good_busy_rise: got %0b want 1", busy); else n_pass++;
    send_byte(8'h03);
    for (int k = 0; k < P; k++) send_byte(8'(k));
    begin
      logic [15:0] c;
      c = crc_model(8'h03, 8'h00);
      send_byte(c[15:8]);
      send_byte(c[7:0]);
    end
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL good_valid_n1: got %0b want 0", frame_valid); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL good_busy_check: got %0b want 1", busy); else n_pass++;
    @(posedge clk); #1;
    exp_good = exp_good + 16'd1;
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL good_valid: got %0b want 1", frame_valid); else n_pass++;
    n_checks++; if (frame_id !== 8'h03) $display("FAIL good_id: got %02h want 03", frame_id); else n_pass++;
    n_checks++; if (frame_payload !== payload_of(8'h00))
      $display("FAIL good_payload: got %h want %h", frame_payload, payload_of(8'h00)); else n_pass++;
    n_checks++; if (good_count !== exp_good) $display("FAIL good_count: got %0d want %0d", good_count, exp_good); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL good_busy_fall: got %0b want 0", busy); else n_pass++;
    consume();
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL good_consumed: got %0b want 0", frame_valid); else n_pass++;
  endtask

  task automatic test_crc_error();
    send_frame(8'h03, 8'h00, 16'h0001);
    @(posedge clk); #1;
    exp_bad = exp_bad + 16'd1;
    n_checks++; if (crc_error !== 1'b1) $display("FAIL crc_pulse: got %0b want 1", crc_error); else n_pass++;
    n_checks++; if (bad_count !== exp_bad) $display("FAIL crc_bad: got %0d want %0d", bad_count, exp_bad); else n_pass++;
    n_checks++; if (good_count !== exp_good) $display("FAIL crc_good: got %0d want %0d", good_count, exp_good); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL crc_valid: got %0b want 0", frame_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (crc_error !== 1'b0) $display("FAIL crc_pulse_width: got %0b want 0", crc_error); else n_pass++;
  endtask

  task automatic test_id_filter();
    id_check_en = 1'b1;
    expected_id = 8'h05;
    send_frame(8'h03, 8'h00, 16'h0000);
    @(posedge clk); #1;
    n_checks++; if (id_mismatch !== 1'b1) $display("FAIL id_pulse: got %0b want 1", id_mismatch); else n_pass++;
    n_checks++; if (good_count !== exp_good || bad_count !== exp_bad)
      $display("FAIL id_counters: got %0d/%0d want %0d/%0d", good_count, bad_count, exp_good, exp_bad); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL id_valid: got %0b want 0", frame_valid); else n_pass++;
    send_frame(8'h05, 8'h00, 16'h0000);
    @(posedge clk); #1;
    exp_good = exp_good + 16'd1;
    n_checks++; if (frame_valid !== 1'b1 || frame_id !== 8'h05)
      $display("FAIL id_accept: got valid=%0b id=%02h want valid=1 id=05", frame_valid, frame_id); else n_pass++;
    n_checks++; if (good_count !== exp_good) $display("FAIL id_good: got %0d want %0d", good_count, exp_good); else n_pass++;
    consume();
    id_check_en = 1'b0;
  endtask

  task automatic test_timeout();
    int lat;
    lat = 0;
    send_magic();
    for (int k = 0; k < 10; k++) send_byte(8'hA0 + 8'(k));
    for (int j = 1; j <= 1100; j++) begin
      @(posedge clk); #1;
      if (timeout_error === 1'b1) begin
        lat = j;
        break;
      end
    end
    exp_bad = exp_bad + 16'd1;
    n_checks++; if (lat < 995 || lat > 1001) $display("FAIL timeout_latency: got %0d cycles want 995..1001", lat); else n_pass++;
    n_checks++; if (bad_count !== exp_bad) $display("FAIL timeout_bad: got %0d want %0d", bad_count, exp_bad); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL timeout_hunt: got busy=%0b want 0", busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (timeout_error !== 1'b0) $display("FAIL timeout_pulse_width: got %0b want 0", timeout_error); else n_pass++;
    send_frame(8'h07, 8'h10, 16'h0000);
    @(posedge clk); #1;
    exp_good = exp_good + 16'd1;
    n_checks++; if (frame_valid !== 1'b1 || frame_payload !== payload_of(8'h10))
      $display("FAIL timeout_recover: got valid=%0b payload=%h want valid=1 payload=%h", frame_valid, frame_payload, payload_of(8'h10)); else n_pass++;
    n_checks++; if (good_count !== exp_good) $display("FAIL timeout_good: got %0d want %0d", good_count, exp_good); else n_pass++;
    consume();
  endtask

  task automatic test_overrun();
    frame_ready = 1'b0;
    send_frame(8'h01, 8'h40, 16'h0000);
    @(posedge clk); #1;
    exp_good = exp_good + 16'd1;
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL ovr_first_valid: got %0b want 1", frame_valid); else n_pass++;
    send_frame(8'h02, 8'h80, 16'h0000);
    @(posedge clk); #1;
    exp_bad = exp_bad + 16'd1;
    n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_pulse: got %0b want 1", overrun); else n_pass++;
    n_checks++; if (frame_id !== 8'h01 || frame_payload !== payload_of(8'h40))
      $display("FAIL ovr_held: got id=%02h payload=%h want id=01 payload=%h", frame_id, frame_payload, payload_of(8'h40)); else n_pass++;
    n_checks++; if (good_count !== exp_good || bad_count !== exp_bad)
      $display("FAIL ovr_counters: got %0d/%0d want %0d/%0d", good_count, bad_count, exp_good, exp_bad); else n_pass++;
    // Release the held frame exactly in the CHECK cycle of the next one.
    send_frame(8'h03, 8'hC0, 16'h0000);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    exp_good = exp_good + 16'd1;
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL ovr_swap_valid: got %0b want 1", frame_valid); else n_pass++;
    n_checks++; if (frame_id !== 8'h03 || frame_payload !== payload_of(8'hC0))
      $display("FAIL ovr_swap_data: got id=%02h payload=%h want id=03 payload=%h", frame_id, frame_payload, payload_of(8'hC0)); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_swap_pulse: got %0b want 0", overrun); else n_pass++;
    n_checks++; if (good_count !== exp_good || bad_count !== exp_bad)
      $display("FAIL ovr_swap_counters: got %0d/%0d want %0d/%0d", good_count, bad_count, exp_good, exp_bad); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (frame_valid !== 1'b1) $display("FAIL ovr_swap_hold: got %0b want 1", frame_valid); else n_pass++;
    consume();
  endtask

  task automatic test_resync_reset();
    send_byte(8'h1C);
    send_frame(8'h09, 8'h20, 16'h0000);
    @(posedge clk); #1;
    exp_good = exp_good + 16'd1;
    n_checks++; if (frame_valid !== 1'b1 || frame_id !== 8'h09)
      $display("FAIL resync_accept: got valid=%0b id=%02h want valid=1 id=09", frame_valid, frame_id); else n_pass++;
    n_checks++; if (good_count !== exp_good) $display("FAIL resync_good: got %0d want %0d", good_count, exp_good); else n_pass++;
    // Held frame stays buffered; reset arrives mid-payload of the next frame.
    send_magic();
    send_byte(8'h09);
    for (int k = 0; k < 5; k++) send_byte(8'h50 + 8'(k));
    #2 reset = 1'b1;
    #1;
    n_checks++; if (frame_valid !== 1'b0 || frame_id !== 8'h00 || frame_payload !== '0)
      $display("FAIL reset_frame: got valid=%0b id=%02h want valid=0 id=00 payload=0", frame_valid, frame_id); else n_pass++;
    n_checks++; if (good_count !== 16'd0 || bad_count !== 16'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", good_count, bad_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 1'b0", busy); else n_pass++;
    n_checks++; if ({crc_error, id_mismatch, timeout_error, overrun} !== 4'b0000)
      $display("FAIL reset_pulses: got %b want 0000", {crc_error, id_mismatch, timeout_error, overrun}); else n_pass++;
    @(posedge clk); #1;
    reset    = 1'b0;
    exp_good = 16'd0;
    exp_bad  = 16'd0;
    send_frame(8'h0A, 8'h30, 16'h0000);
    @(posedge clk); #1;
    exp_good = exp_good + 16'd1;
    n_checks++; if (frame_valid !== 1'b1 || frame_payload !== payload_of(8'h30))
      $display("FAIL reset_recover: got valid=%0b payload=%h want valid=1 payload=%h", frame_valid, frame_payload, payload_of(8'h30)); else n_pass++;
    n_checks++; if (good_count !== exp_good || bad_count !== exp_bad)
      $display("FAIL reset_recover_counters: got %0d/%0d want %0d/%0d", good_count, bad_count, exp_good, exp_bad); else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    rx_data_ready = 1'b0;
    rx_data       = 8'h00;
    id_check_en   = 1'b0;
    expected_id   = 8'h00;
    frame_ready   = 1'b0;
    test_reset();
    test_good_frame();
    test_crc_error();
    test_id_filter();
    test_timeout();
    test_overrun();
    test_resync_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
